// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. Two WIDTH-bit operands are captured on an
// accepted start. One bit per clock (LSB first) then goes through a single
// full-adder cell. When the last bit is done, the registered sum, carry-out
// and signed-overflow flag are updated and done pulses for one cycle.
//
// Optional feature macro: SERIAL_ADDSUB_ACC_EN
//   When this macro is defined, the input acc_i exists. With acc_i=1 at start,
//   the current sum register replaces a_i as operand A, which gives a running
//   total. Without the macro, operand A always comes from a_i.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset, has priority over everything
//   start_i     request, accepted only in IDLE or DONE
//   sub_i       0 = A+B, 1 = A-B (sampled with start)
//   acc_i       accumulate select (only with SERIAL_ADDSUB_ACC_EN)
//   a_i, b_i    operands (sampled with start)
//   busy_o      high while the serial pass is running
//   done_o      one-cycle pulse, result valid
//   sum_o       result, held until the next completion
//   carry_o     carry-out of the MSB stage (subtract: 1 = no borrow)
//   overflow_o  signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
`ifdef SERIAL_ADDSUB_ACC_EN
  input  logic             acc_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  // The counter has one spare bit, so it cannot wrap before it reaches WIDTH.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;     // partial result, not visible on sum_o
  logic             c_q, c_d;         // running carry between bit slices
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] op_a;
  logic             load;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADDSUB_ACC_EN
  assign op_a = acc_i ? sum_q : a_i;
`else
  assign op_a = a_i;
`endif

  // A request is accepted in any state except RUN. During RUN it is dropped,
  // not queued.
  assign load = start_i && (state_q != S_RUN);

  // Single full-adder cell that works on the current LSBs.
  assign fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign fa_co = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d  = {fa_s, res_q[WIDTH-1:1]};
        c_d    = fa_co;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // MSB slice: c_q is the MSB carry-in and fa_co is its carry-out.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          carry_d = fa_co;
          ovf_d   = c_q ^ fa_co;
          state_d = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        if (load) begin
          // Subtraction is A + ~B + 1. The +1 enters as the initial carry.
          a_sh_d  = op_a;
          b_sh_d  = sub_i ? ~b_i : b_i;
          c_d     = sub_i;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor for the switch/LED lab boards. It takes two WIDTH-bit operands from switches, processes one bit per clock (LSB first) through a single full-adder cell, and presents a registered sum, carry, and signed-overflow flag to the LEDs. It replaces the fixed 4-bit combinational adder datapath with a start/done handshake, selectable add/subtract, and an optional accumulate mode.

## Interface

- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is accepting (IDLE or DONE)
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result; holds until next completion
- carry  output  1  final carry-out (subtract: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- acc  input  1  only with SERIAL_ADDSUB_ACC_EN; see Configuration

## Operation

- State machine has three states: IDLE, RUN, and DONE.
  - IDLE: on start=1, load shift registers with A and (sub ? ~B : B), set carry register to sub, bit counter to 0, latch sub, go to RUN.
  - RUN: each cycle, compute the full-adder of A[0], B[0], and c. Shift the result bit into the sum register from the MSB side, shift A and B right, update c, and increment the counter. Record the carry-in of the MSB bit when counter = WIDTH−1. After the WIDTH-th bit, go to DONE.
  - DONE: done=1 for exactly this cycle. On start=1, reload as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- start asserted during RUN is ignored, not queued. a, b, and sub may change freely after the sampling edge.
- Output flags:
  - carry = carry-out of the MSB stage.
  - overflow = carry-in(MSB) XOR carry-out(MSB).
- Arithmetic is modulo 2^WIDTH. sum, carry, and overflow are updated only on entry to DONE. Partial results are never visible on sum.
- Reset values: state IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, counter=0, internal shift registers 0.
- rst has priority over everything. Reset mid-RUN aborts the operation, produces no done pulse, and clears sum/flags to 0.

## Timing

- Start accepted at edge k. busy is high during cycles k+1 … k+WIDTH. done is high and results are valid in cycle k+WIDTH+1.
- Latency is WIDTH+1 cycles from the accepting edge to done.
- Throughput is one result per WIDTH+1 cycles with back-to-back start held in DONE.
- busy and done are never high together.
- Counter width is clog2(WIDTH)+1 bits, so it must not wrap before WIDTH.

## Configuration

- SERIAL_ADDSUB_ACC_EN defined: adds input acc, sampled with start.
  - With acc=1, the current sum register is used as operand A instead of a. This gives running-total accumulation (sum ← sum ± b).
  - acc=0 behaves exactly as without the macro.
- SERIAL_ADDSUB_ACC_EN undefined: the acc port does not exist, and A is always taken from a.
- Timing, reset behaviour, and flags are identical in both builds.

## Test plan

- WIDTH=8, a=8'h35, b=8'h4A, sub=0, start pulse at edge k → busy for 8 cycles; done only in cycle k+9; sum=8'h7F, carry=0, overflow=0.
- a=8'h7F, b=8'h01, add → sum=8'h80, carry=0, overflow=1. Then a=8'hFF, b=8'h01 → sum=8'h00, carry=1, overflow=0.
- a=8'h10, b=8'h20, sub=1 → sum=8'hF0, carry=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 → sum=8'h7F, carry=1, overflow=1.
- Start at k, hold start=1 with new operands during RUN → second request ignored. start still high in DONE → new operation begins; next done at DONE+9.
- Assert rst at the 4th RUN cycle of 8'hAA+8'h55 → next cycle IDLE, busy=0, sum=0; no done pulse ever follows.
- With SERIAL_ADDSUB_ACC_EN: reset, then three operations with acc=1, b=8'h64, add → sums 8'h64, 8'hC8, 8'h2C; carry=1 on the third, overflow=1 on the second only.
